// File: rtl/z_result_fifo.sv
// z_result_fifo
//   DEPTH-entry circular queue of double-width ALU results ({hi,lo}).
//   The head entry is presented combinationally; either half can be driven
//   onto the internal bus without consuming it. Occupancy is tracked by an
//   explicit counter, so the pointers wrap naturally modulo DEPTH and need no
//   extra wrap bit. Sticky overflow/underflow flags report dropped pushes and
//   pops on an empty queue to the control unit.
module z_result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2*WIDTH-1:0] from_ALU,
    input  logic               Z_in,
    input  logic               Z_pop,
    input  logic               Z_out,
    input  logic               Z_sel_hi,
    input  logic               Z_clr_err,
    output logic [WIDTH-1:0]   out_to_bus,
    output logic [WIDTH-1:0]   REG_OUT_Z1,
    output logic [WIDTH-1:0]   REG_OUT_Z2,
    output logic [CW-1:0]      Z_count,
    output logic               Z_empty,
    output logic               Z_full,
    output logic               Z_overflow,
    output logic               Z_underflow
);

    // Pointer width; DEPTH is a power of two >= 2, so AW >= 1 and the
    // pointers wrap modulo DEPTH by plain binary overflow.
    localparam int AW = $clog2(DEPTH);

    // Entry storage. Deliberately not reset: stale contents are masked by the
    // empty-gating on every data output.
    logic [2*WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          ovf_q,    ovf_d;
    logic          unf_q,    unf_d;

    logic          empty;
    logic          full;
    logic          push_ok;
    logic          pop_ok;
    logic          ovf_evt;
    logic          unf_evt;

    logic [2*WIDTH-1:0] head;
    logic [WIDTH-1:0]   head_lo;
    logic [WIDTH-1:0]   head_hi;
    logic [WIDTH-1:0]   bus_sel;

    // Status decode and push/pop qualification from the current occupancy.
    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CW'(DEPTH));
        // A pop only retires an entry when one exists.
        pop_ok  = Z_pop && !empty;
        // When full, a simultaneous pop frees the head slot this same edge,
        // so the push can be taken; otherwise a push into a full queue drops.
        push_ok = Z_in && (!full || Z_pop);
        // Error events: dropped push, and pop requested while empty. A pop on
        // empty is flagged even when a push is accepted alongside it.
        ovf_evt = Z_in && full && !Z_pop;
        unf_evt = Z_pop && empty;
    end

    // Next-state computation for pointers, occupancy and sticky flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // Simultaneous accepted push and pop cancel and leave the count as is.
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        // Clear takes effect at the edge, but an error in the same cycle
        // re-sets the flag (set has priority over clear).
        ovf_d = (ovf_q && !Z_clr_err) || ovf_evt;
        unf_d = (unf_q && !Z_clr_err) || unf_evt;
    end

    // Control state: asynchronous active-low reset discards all entries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage write at the tail; a dropped push leaves storage untouched.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= from_ALU;
        end
    end

    // Head read path: zero-latency view of the stored head, forced to zero
    // while empty. There is no bypass from from_ALU, so a value pushed this
    // cycle only appears after the push edge.
    always_comb begin
        head    = mem_q[rd_ptr_q];
        head_lo = empty ? '0 : head[WIDTH-1:0];
        head_hi = empty ? '0 : head[2*WIDTH-1:WIDTH];
        bus_sel = Z_sel_hi ? head_hi : head_lo;
    end

    assign REG_OUT_Z1  = head_lo;
    assign REG_OUT_Z2  = head_hi;
    // Driving the bus never consumes the head; it can be held for many cycles.
    assign out_to_bus  = (Z_out && !empty) ? bus_sel : '0;
    assign Z_count     = count_q;
    assign Z_empty     = empty;
    assign Z_full      = full;
    assign Z_overflow  = ovf_q;
    assign Z_underflow = unf_q;

endmodule

// File: tb/tb_z_result_fifo.sv
// Testbench for z_result_fifo: directed scenarios followed by randomized
// push/pop/clear/reset traffic compared against a queue-based reference.
module tb_z_result_fifo;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    logic           clk;
    logic           reset;
    logic [2*W-1:0] from_ALU;
    logic           Z_in;
    logic           Z_pop;
    logic           Z_out;
    logic           Z_sel_hi;
    logic           Z_clr_err;
    logic [W-1:0]   out_to_bus;
    logic [W-1:0]   REG_OUT_Z1;
    logic [W-1:0]   REG_OUT_Z2;
    logic [CW-1:0]  Z_count;
    logic           Z_empty;
    logic           Z_full;
    logic           Z_overflow;
    logic           Z_underflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [2*W-1:0] mq[$];
    bit             m_ovf;
    bit             m_unf;

    z_result_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .from_ALU   (from_ALU),
        .Z_in       (Z_in),
        .Z_pop      (Z_pop),
        .Z_out      (Z_out),
        .Z_sel_hi   (Z_sel_hi),
        .Z_clr_err  (Z_clr_err),
        .out_to_bus (out_to_bus),
        .REG_OUT_Z1 (REG_OUT_Z1),
        .REG_OUT_Z2 (REG_OUT_Z2),
        .Z_count    (Z_count),
        .Z_empty    (Z_empty),
        .Z_full     (Z_full),
        .Z_overflow (Z_overflow),
        .Z_underflow(Z_underflow)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Apply the queue rules for one clock edge with the given requests.
    task automatic model_edge(input bit in, input logic [2*W-1:0] d, input bit pop, input bit clr);
        int n;
        bit was_full, was_empty;
        n         = mq.size();
        was_full  = (n == D);
        was_empty = (n == 0);
        if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (in && was_full && !pop) m_ovf = 1'b1;
        if (pop && was_empty)       m_unf = 1'b1;
        if (pop && !was_empty)      void'(mq.pop_front());
        if (in && (!was_full || pop)) mq.push_back(d);
    endtask

    // Compare every output against the model, sweeping the bus controls.
    task automatic compare_all();
        logic [2*W-1:0] hd;
        logic [W-1:0]   exp_bus;
        hd = (mq.size() > 0) ? mq[0] : '0;
        check("count",     64'(Z_count),     64'(mq.size()));
        check("empty",     64'(Z_empty),     64'(mq.size() == 0));
        check("full",      64'(Z_full),      64'(mq.size() == D));
        check("overflow",  64'(Z_overflow),  64'(m_ovf));
        check("underflow", 64'(Z_underflow), 64'(m_unf));
        check("z1",        64'(REG_OUT_Z1),  64'(hd[W-1:0]));
        check("z2",        64'(REG_OUT_Z2),  64'(hd[2*W-1:W]));
        for (int o = 0; o < 2; o++) begin
            for (int s = 0; s < 2; s++) begin
                Z_out    = o[0];
                Z_sel_hi = s[0];
                #1;
                if (o == 1 && mq.size() > 0) exp_bus = s[0] ? hd[2*W-1:W] : hd[W-1:0];
                else                         exp_bus = '0;
                check("bus", 64'(out_to_bus), 64'(exp_bus));
            end
        end
        Z_out    = 1'b0;
        Z_sel_hi = 1'b0;
    endtask

    // One clock: requests applied, pre-edge state checked at the falling
    // edge, model advanced at the rising edge, requests removed after it.
    task automatic cycle(input bit in, input logic [2*W-1:0] d, input bit pop, input bit clr);
        Z_in      = in;
        from_ALU  = d;
        Z_pop     = pop;
        Z_clr_err = clr;
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_edge(in, d, pop, clr);
        #1;
        Z_in      = 1'b0;
        Z_pop     = 1'b0;
        Z_clr_err = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        from_ALU  = '0;
        Z_in      = 1'b0;
        Z_pop     = 1'b0;
        Z_out     = 1'b0;
        Z_sel_hi  = 1'b0;
        Z_clr_err = 1'b0;
        model_reset();

        // 1: reset held two clocks, then released
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        Z_out = 1'b1;
        #1;
        check("t1_bus",   64'(out_to_bus), 64'h0);
        check("t1_empty", 64'(Z_empty),    64'h1);
        check("t1_count", 64'(Z_count),    64'h0);
        check("t1_flags", 64'({Z_overflow, Z_underflow}), 64'h0);
        Z_out = 1'b0;
        @(posedge clk);
        #1;

        // 2: single push, both halves on the bus; invisible on the push cycle
        Z_in     = 1'b1;
        from_ALU = 32'h0001_ABAA;
        Z_out    = 1'b1;
        #1;
        check("t2_nobypass", 64'(out_to_bus), 64'h0);
        Z_out = 1'b0;
        @(posedge clk);
        model_edge(1'b1, 32'h0001_ABAA, 1'b0, 1'b0);
        #1;
        Z_in = 1'b0;
        check("t2_z1", 64'(REG_OUT_Z1), 64'hABAA);
        check("t2_z2", 64'(REG_OUT_Z2), 64'h0001);
        Z_out = 1'b1; Z_sel_hi = 1'b0; #1;
        check("t2_bus_lo", 64'(out_to_bus), 64'hABAA);
        Z_sel_hi = 1'b1; #1;
        check("t2_bus_hi", 64'(out_to_bus), 64'h0001);
        Z_out = 1'b0; Z_sel_hi = 1'b0;
        cycle(1'b0, '0, 1'b1, 1'b0);

        // 3: fill to DEPTH, then a dropped push
        cycle(1'b1, 32'h0000_0000, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_FFFF, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_1234, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_5678, 1'b0, 1'b0);
        check("t3_full",  64'(Z_full),  64'h1);
        check("t3_count", 64'(Z_count), 64'h4);
        cycle(1'b1, 32'h0000_DEAD, 1'b0, 1'b0);
        check("t3_ovf",   64'(Z_overflow), 64'h1);
        check("t3_head",  64'(REG_OUT_Z1), 64'h0);
        check("t3_count2", 64'(Z_count),   64'h4);

        // 4: push+pop while full, then drain across the wrap
        cycle(1'b1, 32'h0000_9999, 1'b1, 1'b0);
        check("t4_count", 64'(Z_count), 64'h4);
        check("t4_pop1", 64'(REG_OUT_Z1), 64'hFFFF);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("t4_pop2", 64'(REG_OUT_Z1), 64'h1234);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("t4_pop3", 64'(REG_OUT_Z1), 64'h5678);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("t4_pop4", 64'(REG_OUT_Z1), 64'h9999);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("t4_empty", 64'(Z_empty), 64'h1);

        // 5: pop on empty together with a push
        cycle(1'b1, 32'h0000_00AA, 1'b1, 1'b0);
        check("t5_unf",   64'(Z_underflow), 64'h1);
        check("t5_count", 64'(Z_count),     64'h1);
        check("t5_head",  64'(REG_OUT_Z1),  64'h00AA);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("t5_clr", 64'({Z_overflow, Z_underflow}), 64'h0);

        // 6: asynchronous reset with entries queued
        cycle(1'b1, 32'h1111_2222, 1'b0, 1'b0);
        cycle(1'b1, 32'h3333_4444, 1'b0, 1'b0);
        check("t6_count3", 64'(Z_count), 64'h3);
        #2;
        reset = 1'b0;
        Z_out = 1'b1;
        #1;
        check("t6_bus0",   64'(out_to_bus), 64'h0);
        check("t6_z1_0",   64'(REG_OUT_Z1), 64'h0);
        check("t6_z2_0",   64'(REG_OUT_Z2), 64'h0);
        check("t6_count0", 64'(Z_count),    64'h0);
        Z_out = 1'b0;
        model_reset();
        reset = 1'b1;
        cycle(1'b1, 32'hCAFE_4242, 1'b0, 1'b0);
        check("t6_mem0", 64'(dut.mem_q[0]), 64'hCAFE_4242);
        check("t6_head", 64'(REG_OUT_Z2),   64'hCAFE);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bit             r_in, r_pop, r_clr;
            logic [2*W-1:0] r_d;
            r_in  = ($urandom_range(0, 99) < 55);
            r_pop = ($urandom_range(0, 99) < 45);
            r_clr = ($urandom_range(0, 15) == 0);
            r_d   = $urandom;
            cycle(r_in, r_d, r_pop, r_clr);
            if ($urandom_range(0, 199) == 0) pulse_reset();
        end
        @(negedge clk);
        compare_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
